// File: rtl/pim_chunk_engine.sv
// pim_chunk_engine: one PIM compute unit. Latches a CHUNK_SIZE x MATRIX_SIZE
// row-chunk of A and a MATRIX_SIZE x CHUNK_SIZE column-chunk of B on a start
// request. It computes their CHUNK_SIZE x CHUNK_SIZE product with a single
// sequential MAC and holds the finished tile with result_valid until the
// controller drops valid.
// Optional feature macro: PIM_SATURATE_EN. When it is defined, each result
// element clamps to 2**WIDTH-1. Otherwise each element keeps the low WIDTH
// bits of the exact sum.
// MAC pipeline: p0 issues indices, p1 holds the registered product, and p2
// accumulates and writes the result. The final write lands one edge after the
// last issue, so result_valid rises CHUNK_SIZE**2*MATRIX_SIZE+1 edges after
// capture.
module pim_chunk_engine #(
  parameter int ID          = 0,
  parameter int WIDTH       = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int CHUNK_SIZE  = MATRIX_SIZE / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] matrixA [CHUNK_SIZE][MATRIX_SIZE],
  input  logic [WIDTH-1:0] matrixB [MATRIX_SIZE][CHUNK_SIZE],
  output logic [WIDTH-1:0] result  [CHUNK_SIZE*CHUNK_SIZE],
  output logic             result_valid,
  output logic             busy
);

  localparam int NRES = CHUNK_SIZE * CHUNK_SIZE;
  localparam int AW   = 2 * WIDTH + $clog2(MATRIX_SIZE);
  localparam int PW   = 2 * WIDTH;
  localparam int RW   = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam int KW   = $clog2(MATRIX_SIZE);
  localparam int IW   = (NRES > 1) ? $clog2(NRES) : 1;

  localparam logic [RW-1:0] RC_LAST = RW'(CHUNK_SIZE - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(MATRIX_SIZE - 1);

  // Elaboration guard: a malformed configuration stops the build.
  if (ID < 0 || MATRIX_SIZE < 2 || CHUNK_SIZE < 1) begin : g_param_check
    $error("pim_chunk_engine: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t state_q, state_d;

  // Operand snapshot, which isolates the running job from its inputs.
  logic [WIDTH-1:0] opA [CHUNK_SIZE][MATRIX_SIZE];
  logic [WIDTH-1:0] opB [MATRIX_SIZE][CHUNK_SIZE];

  logic [RW-1:0] r_p0, c_p0;
  logic [KW-1:0] k_p0;
  logic          issue_done_p0;

  logic [PW-1:0] prod_p1;
  logic [IW-1:0] idx_p1;
  logic          vld_p1, wrap_p1, last_p1;

  logic [AW-1:0] acc_p2;
  logic [AW-1:0] sum_p1;

  logic capture;

  // Output conversion of an exact sum to an element.
  function automatic logic [WIDTH-1:0] to_elem(input logic [AW-1:0] s);
`ifdef PIM_SATURATE_EN
    if (s > AW'({WIDTH{1'b1}})) return {WIDTH{1'b1}};
    else                        return WIDTH'(s);
`else
    return WIDTH'(s);
`endif
  endfunction

  assign capture      = (state_q == IDLE) && valid;
  assign busy         = (state_q == COMPUTE);
  assign result_valid = (state_q == DONE);
  assign sum_p1       = acc_p2 + AW'(prod_p1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: the job ends when the last element's sum is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = COMPUTE;
      COMPUTE: if (vld_p1 && last_p1) state_d = DONE;
      DONE:    if (!valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- p0 -> p1: snapshot, index walk, product register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHUNK_SIZE; i++)
        for (int j = 0; j < MATRIX_SIZE; j++) opA[i][j] <= '0;
      for (int i = 0; i < MATRIX_SIZE; i++)
        for (int j = 0; j < CHUNK_SIZE; j++) opB[i][j] <= '0;
      r_p0          <= '0;
      c_p0          <= '0;
      k_p0          <= '0;
      issue_done_p0 <= 1'b0;
      prod_p1       <= '0;
      idx_p1        <= '0;
      vld_p1        <= 1'b0;
      wrap_p1       <= 1'b0;
      last_p1       <= 1'b0;
    end else if (capture) begin
      opA           <= matrixA;
      opB           <= matrixB;
      r_p0          <= '0;
      c_p0          <= '0;
      k_p0          <= '0;
      issue_done_p0 <= 1'b0;
      vld_p1        <= 1'b0;
    end else if (state_q == COMPUTE && !issue_done_p0) begin
      prod_p1 <= PW'(opA[r_p0][k_p0]) * PW'(opB[k_p0][c_p0]);
      idx_p1  <= IW'(r_p0) * IW'(CHUNK_SIZE) + IW'(c_p0);
      vld_p1  <= 1'b1;
      wrap_p1 <= (k_p0 == K_LAST);
      last_p1 <= (r_p0 == RC_LAST) && (c_p0 == RC_LAST) && (k_p0 == K_LAST);
      if (k_p0 == K_LAST) begin
        k_p0 <= '0;
        if (c_p0 == RC_LAST) begin
          c_p0 <= '0;
          if (r_p0 == RC_LAST) issue_done_p0 <= 1'b1;
          else                 r_p0 <= r_p0 + 1'b1;
        end else begin
          c_p0 <= c_p0 + 1'b1;
        end
      end else begin
        k_p0 <= k_p0 + 1'b1;
      end
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  // ---- p1 -> p2: accumulate, write the element at each k wrap ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p2 <= '0;
      for (int i = 0; i < NRES; i++) result[i] <= '0;
    end else if (capture) begin
      acc_p2 <= '0;
      for (int i = 0; i < NRES; i++) result[i] <= '0;
    end else if (vld_p1) begin
      if (wrap_p1) begin
        result[idx_p1] <= to_elem(sum_p1);
        acc_p2         <= '0;
      end else begin
        acc_p2 <= sum_p1;
      end
    end
  end

endmodule
